// File: rtl/gest_interrup_vec.sv
// rtl/gest_interrup_vec.sv - vectored interrupt controller: edge-latched pending bits, fixed priority, one-shot dispatch held until fin
module gest_interrup_vec #(
    parameter int N_SRC      = 4,
    parameter int DIR_W      = 10,
    parameter int VEC_BASE   = 984,
    parameter int VEC_STRIDE = 10,
    localparam int ID_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq,
    input  logic [N_SRC-1:0] mask,
    input  logic             enable,
    input  logic             fin,
    output logic [DIR_W-1:0] dir,
    output logic             s_interrup,
    output logic             busy,
    output logic [ID_W-1:0]  cur_id,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   irq_prev_q, irq_prev_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic               s_interrup_q, s_interrup_d;
    logic               busy_q, busy_d;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   cand;
    logic [N_SRC-1:0]   win_oh;
    logic [N_SRC-1:0]   clr;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;

    assign rise = irq & ~irq_prev_q;
    assign cand = pending_q & mask;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        win_id  = '0;
        win_vld = 1'b0;
        win_oh  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_id    = ID_W'(i);
                win_vld   = 1'b1;
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cur_id_d     = cur_id_q;
        s_interrup_d = 1'b0;
        busy_d       = busy_q;
        clr          = '0;
        irq_prev_d   = irq;
        case (state_q)
            IDLE: begin
                if (enable && win_vld) begin
                    state_d      = REQ;
                    dir_d        = DIR_W'(VEC_BASE) + DIR_W'(VEC_STRIDE) * DIR_W'(win_id);
                    cur_id_d     = win_id;
                    s_interrup_d = 1'b1;
                    busy_d       = 1'b1;
                    clr          = win_oh;
                end
            end
            REQ: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (fin) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    dir_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                dir_d   = '0;
            end
        endcase
        // A fresh edge on the source being dispatched re-arms it.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            dir_q        <= '0;
            cur_id_q     <= '0;
            s_interrup_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_prev_d;
            dir_q        <= dir_d;
            cur_id_q     <= cur_id_d;
            s_interrup_q <= s_interrup_d;
            busy_q       <= busy_d;
        end
    end

    assign dir        = dir_q;
    assign s_interrup = s_interrup_q;
    assign busy       = busy_q;
    assign cur_id     = cur_id_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_gest_interrup_vec.sv
// tb/tb_gest_interrup_vec.sv - directed vector table plus multi-cycle sequences for gest_interrup_vec
module tb_gest_interrup_vec;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       enable;
    logic       fin;
    logic [9:0] dir;
    logic       s_interrup;
    logic       busy;
    logic [1:0] cur_id;
    logic [3:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    gest_interrup_vec dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask       (mask),
        .enable     (enable),
        .fin        (fin),
        .dir        (dir),
        .s_interrup (s_interrup),
        .busy       (busy),
        .cur_id     (cur_id),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic [3:0] mask;
        logic       en;
        logic       fin;
        logic       s;
        logic       b;
        logic [9:0] dir;
        logic [1:0] id;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] i, logic [3:0] m, logic e, logic f,
                                logic s, logic b, logic [9:0] d, logic [1:0] id, logic [3:0] p);
        vec_t v;
        v.irq = i; v.mask = m; v.en = e; v.fin = f;
        v.s = s; v.b = b; v.dir = d; v.id = id; v.pend = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int pulses;
        logic found;

        reset = 1'b1; irq = '0; mask = 4'b1111; enable = 1'b1; fin = 1'b0;

        //          irq      mask     en  fin  s  b  dir   id pend
        tbl.push_back(mk(4'b0000, 4'b1111, 1, 0, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 0, 0, 0,    0, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 1, 1, 984,  0, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 0, 1, 984,  0, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 1, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 0, 0, 0, 0,    0, 4'b1010));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 0, 1, 1, 994,  1, 4'b1000));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 0, 0, 1, 994,  1, 4'b1000));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 1, 0, 0, 0,    1, 4'b1000));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 0, 1, 1, 1014, 3, 4'b0000));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 0, 0, 1, 1014, 3, 4'b0000));
        tbl.push_back(mk(4'b1010, 4'b1111, 1, 1, 0, 0, 0,    3, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b1111, 1, 1, 0, 0, 0,    3, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b1111, 1, 0, 0, 0, 0,    3, 4'b0100));
        tbl.push_back(mk(4'b0100, 4'b1111, 1, 0, 1, 1, 1004, 2, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b1111, 1, 1, 0, 1, 1004, 2, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b1111, 1, 0, 0, 1, 1004, 2, 4'b0000));
        tbl.push_back(mk(4'b0100, 4'b1111, 1, 1, 0, 0, 0,    2, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b1111, 1, 0, 0, 0, 0,    2, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b1110, 1, 0, 0, 0, 0,    2, 4'b0001));
        tbl.push_back(mk(4'b0000, 4'b1110, 1, 0, 0, 0, 0,    2, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 1, 1, 984,  0, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 0, 1, 984,  0, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 1, 0, 0, 0,    0, 4'b0001));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 1, 1, 984,  0, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 0, 0, 1, 984,  0, 4'b0000));
        tbl.push_back(mk(4'b0001, 4'b1111, 1, 1, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 0, 0, 0, 0,    0, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b1111, 0, 0, 0, 0, 0,    0, 4'b0010));
        tbl.push_back(mk(4'b0010, 4'b1111, 0, 0, 0, 0, 0,    0, 4'b0010));
        tbl.push_back(mk(4'b0010, 4'b1111, 1, 0, 1, 1, 994,  1, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b1111, 0, 0, 0, 1, 994,  1, 4'b0000));
        tbl.push_back(mk(4'b0010, 4'b1111, 0, 1, 0, 0, 0,    1, 4'b0000));

        step();
        step();
        chk("reset_s", 32'(s_interrup), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dir", 32'(dir), 0);
        chk("reset_id", 32'(cur_id), 0);
        chk("reset_pend", 32'(pending), 0);
        reset = 1'b0;

        foreach (tbl[k]) begin
            irq = tbl[k].irq; mask = tbl[k].mask; enable = tbl[k].en; fin = tbl[k].fin;
            step();
            chk($sformatf("v%0d_s", k),    32'(s_interrup), 32'(tbl[k].s));
            chk($sformatf("v%0d_busy", k), 32'(busy),       32'(tbl[k].b));
            chk($sformatf("v%0d_dir", k),  32'(dir),        32'(tbl[k].dir));
            chk($sformatf("v%0d_id", k),   32'(cur_id),     32'(tbl[k].id));
            chk($sformatf("v%0d_pend", k), 32'(pending),    32'(tbl[k].pend));
        end

        // Masked source stays pending, then dispatches once unmasked.
        fin = 1'b0; enable = 1'b1; mask = 4'b1011; irq = 4'b0100;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_interrup !== 1'b0) bad++;
        end
        chk("masked_no_dispatch", 32'(bad), 0);
        chk("masked_pend2", 32'(pending[2]), 1);
        mask = 4'b1111;
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            step();
            if (s_interrup === 1'b1) found = 1'b1;
        end
        chk("unmask_dispatch", 32'(found), 1);
        chk("unmask_dir", 32'(dir), 1004);

        // No preemption: higher-priority edge during service only latches.
        step();
        irq = 4'b0101;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (dir !== 10'd1004 || busy !== 1'b1 || s_interrup !== 1'b0) bad++;
        end
        chk("no_preempt", 32'(bad), 0);
        chk("preempt_pend0", 32'(pending[0]), 1);
        fin = 1'b1;
        step();
        chk("fin_busy", 32'(busy), 0);
        fin = 1'b0;
        step();
        chk("next_s", 32'(s_interrup), 1);
        chk("next_dir", 32'(dir), 984);
        chk("next_id", 32'(cur_id), 0);
        step();
        fin = 1'b1;
        step();
        fin = 1'b0;

        // Held level gives a single dispatch.
        irq = 4'b0000;
        step();
        irq = 4'b0010;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (s_interrup === 1'b1) pulses++;
            fin = busy && !s_interrup;
        end
        chk("held_one_dispatch", 32'(pulses), 1);
        chk("held_idle", 32'(busy), 0);

        // Repeated edges while pending collapse to one request.
        fin = 1'b0; irq = 4'b0000; mask = 4'b1101;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            irq = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
            if (s_interrup === 1'b1) pulses++;
        end
        chk("toggle_pend1", 32'(pending), 32'(4'b0010));
        mask = 4'b1111; irq = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_interrup === 1'b1) pulses++;
            fin = busy && !s_interrup;
        end
        chk("toggle_one_dispatch", 32'(pulses), 1);
        fin = 1'b0;

        // Asynchronous reset in the middle of service.
        irq = 4'b0000;
        step();
        irq = 4'b0111;
        step();
        chk("pre_rst_pend", 32'(pending), 32'(4'b0111));
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_pend2", 32'(pending), 32'(4'b0110));
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s", 32'(s_interrup), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_dir", 32'(dir), 0);
        #2 reset = 1'b0;
        step();
        chk("post_rst_pend", 32'(pending), 32'(4'b0111));
        step();
        chk("post_rst_s", 32'(s_interrup), 1);
        chk("post_rst_dir", 32'(dir), 984);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
